// File: rtl/div_8by4_seq.sv
// div_8by4_seq -- sequential sign-magnitude 8-bit by 4-bit divider.
//
// Restoring division, one quotient bit per clock, MSB first. A request in
// IDLE latches the operands, RUN performs eight iterations, and DONE
// publishes the registered results with a one-cycle done pulse before
// returning to IDLE. Results hold until the next completed operation.
//
// Optional feature: define DIV_ZERO_CHECK_EN to detect a zero divisor at
// start. The divider then skips the iterations, reports q = 8'hFF, r = 0,
// both signs 0 and raises dz. Without the macro dz is tied low and a zero
// divisor simply runs the normal eight iterations.
//
// Reset is synchronous and active-high; it aborts any operation in flight.

module div_8by4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [3:0] b,
  input  logic       asign,
  input  logic       bsign,
  input  logic       start,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       qsign,
  output logic       rsign,
  output logic       busy,
  output logic       done,
  output logic       dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;

  // Working registers, loaded at start and private to the operation so that
  // operand inputs may change freely while RUN is in progress.
  logic [7:0] dvd;        // dividend, shifted left; bit 7 feeds the remainder
  logic [3:0] dvs;        // latched divisor magnitude
  logic       asign_l;    // latched dividend sign
  logic       bsign_l;    // latched divisor sign
  logic [3:0] prem;       // partial remainder between iterations (always < b)
  logic [7:0] quo;        // quotient bits collected MSB first
  logic [2:0] iter;       // iteration index 0..7

`ifdef DIV_ZERO_CHECK_EN
  logic       dz_pend;    // operation was started with a zero divisor
`endif

  // One restoring step. The shifted remainder is five bits wide; after the
  // conditional subtract the result is below the divisor, so four bits are
  // enough to carry it into the next step.
  logic [4:0] shifted;
  logic       ge;
  logic [3:0] diff;
  logic [3:0] next_prem;

  // Combinational iteration datapath: shift, compare, conditionally subtract.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (defaults
    // first) so no latch is inferred.
    shifted   = {prem, dvd[7]};
    ge        = 1'b0;
    diff      = 4'd0;
    next_prem = shifted[3:0];
    if (shifted >= {1'b0, dvs}) begin
      ge        = 1'b1;
      // The true difference is below 16 here, so a 4-bit subtract is exact.
      diff      = shifted[3:0] - dvs;
      next_prem = diff;
    end
  end

  // Control FSM, datapath registers and registered outputs in one process.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      dvd     <= 8'd0;
      dvs     <= 4'd0;
      asign_l <= 1'b0;
      bsign_l <= 1'b0;
      prem    <= 4'd0;
      quo     <= 8'd0;
      iter    <= 3'd0;
      q       <= 8'd0;
      r       <= 4'd0;
      qsign   <= 1'b0;
      rsign   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dz_pend <= 1'b0;
      dz      <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse; only DONE raises it.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            dvd     <= a;
            dvs     <= b;
            asign_l <= asign;
            bsign_l <= bsign;
            prem    <= 4'd0;
            quo     <= 8'd0;
            iter    <= 3'd0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef DIV_ZERO_CHECK_EN
            dz_pend <= (b == 4'd0);
            dz      <= 1'b0;
`endif
          end
        end

        RUN: begin
`ifdef DIV_ZERO_CHECK_EN
          if (dz_pend) begin
            // Zero divisor: no iterations, go straight to publishing.
            busy  <= 1'b0;
            state <= DONE;
          end else
`endif
          begin
            dvd  <= {dvd[6:0], 1'b0};
            quo  <= {quo[6:0], ge};
            prem <= next_prem;
            iter <= iter + 3'd1;
            if (iter == 3'd7) begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end

        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
`ifdef DIV_ZERO_CHECK_EN
          if (dz_pend) begin
            q     <= 8'hFF;
            r     <= 4'h0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            dz    <= 1'b1;
          end else
`endif
          begin
            q     <= quo;
            r     <= prem;
            // A zero magnitude is always reported as positive.
            qsign <= (asign_l ^ bsign_l) & (quo != 8'd0);
            rsign <= asign_l & (prem != 4'd0);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef DIV_ZERO_CHECK_EN
  // Divide-by-zero detection is compiled out; the flag never rises.
  assign dz = 1'b0;
`endif

endmodule
